// File: rtl/coe_accum.sv
// Packet accumulator: sums unsigned coefficient words into a guarded, saturating
// accumulator and presents one {sum, count, overflow} result per packet.
`ifndef W_COE
`define W_COE 8
`endif

module coe_accum #(
  parameter int WIDTH = `W_COE,
  parameter int GUARD = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+GUARD-1:0] out_sum,
  output logic [CNT_W-1:0]       out_cnt,
  output logic                   out_ovf
);

  localparam int ACC_W = WIDTH + GUARD;

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             beat;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  // Ready is purely a function of state and clr so it never loops back on in_valid.
  assign in_ready = (state == ACC) && !clr;
  assign beat     = in_valid && in_ready;

  // The extra carry bit detects wrap; a saturated acc stays all-ones because any
  // further nonzero word carries out again and a zero word leaves it unchanged.
  always_comb begin
    sum_wide = {1'b0, acc} + {{(GUARD + 1){1'b0}}, in_data};
    acc_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    ovf_next = ovf | sum_wide[ACC_W];
    cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (beat) begin
            if (in_last) begin
              out_sum   <= acc_next;
              out_cnt   <= cnt_next;
              out_ovf   <= ovf_next;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= HOLD;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
              ovf <= ovf_next;
            end
          end
        end
        HOLD: begin
          // Result stays on out_* after the handshake; only out_valid drops.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_coe_accum.sv
// Self-checking bench for coe_accum: directed vector table, hand sequences for
// saturation/reset corners, and a randomized run against a packet-level model.
module tb_coe_accum;

  localparam int WIDTH   = 8;
  localparam int GUARD   = 4;
  localparam int CNT_W   = 8;
  localparam int ACC_W   = WIDTH + GUARD;
  localparam longint SUM_MAX = (longint'(1) << ACC_W) - 1;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  int n_total = 0;
  int n_pass  = 0;

  coe_accum #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic      v;
    int        d;
    logic      l;
    logic      c;
    logic      o;
    logic      e_ready;
    logic      e_ovalid;
    longint    e_sum;
    longint    e_cnt;
    logic      e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic v, input int d, input logic l, input logic c,
                     input logic o, input logic er, input logic eov,
                     input longint es, input longint ec, input logic eo);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.c = c; t.o = o;
    t.e_ready = er; t.e_ovalid = eov; t.e_sum = es; t.e_cnt = ec; t.e_ovf = eo;
    vecs.push_back(t);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic drive(input logic v, input int d, input logic l, input logic c,
                       input logic o);
    in_valid  = v;
    in_data   = d[WIDTH-1:0];
    in_last   = l;
    clr       = c;
    out_ready = o;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ov, input longint s,
                           input longint c, input logic f);
    check({tag, " out_valid"}, out_valid, ov);
    check({tag, " out_sum"},   out_sum,   s);
    check({tag, " out_cnt"},   out_cnt,   c);
    check({tag, " out_ovf"},   out_ovf,   f);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  // Packet-level reference: a saturating sum of nonnegative words equals the
  // clamped total, and overflow happened iff the total exceeds the maximum.
  int     pkt[$];
  logic   m_busy;
  longint m_sum, m_cnt;
  logic   m_ovf;

  task automatic model_reset();
    pkt.delete();
    m_busy = 1'b0; m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
  endtask

  task automatic model_finish_packet();
    longint tot = 0;
    foreach (pkt[i]) tot += pkt[i];
    m_sum  = (tot > SUM_MAX) ? SUM_MAX : tot;
    m_ovf  = (tot > SUM_MAX);
    m_cnt  = (pkt.size() > CNT_MAX) ? CNT_MAX : pkt.size();
    m_busy = 1'b1;
    pkt.delete();
  endtask

  initial begin
    // ---- directed vector table ----
    add(1, 10, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1, 20, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1, 30, 1, 0, 1, 1, 1, 60, 3, 0);
    add(0, 0, 0, 0, 1, 0, 0, 60, 3, 0);
    add(0, 0, 0, 0, 1, 1, 0, 60, 3, 0);
    add(1, 3, 0, 0, 0, 1, 0, 60, 3, 0);
    add(1, 4, 1, 0, 0, 1, 1, 7, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1, 7, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1, 7, 2, 0);
    add(1, 55, 1, 1, 0, 0, 1, 7, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1, 7, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1, 7, 2, 0);
    add(0, 0, 0, 0, 1, 0, 0, 7, 2, 0);
    add(1, 5, 0, 0, 1, 1, 0, 7, 2, 0);
    add(1, 5, 0, 0, 1, 1, 0, 7, 2, 0);
    add(1, 99, 0, 1, 1, 0, 0, 7, 2, 0);
    add(1, 7, 1, 0, 1, 1, 1, 7, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 7, 1, 0);
    add(1, 0, 1, 0, 1, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 9, 0, 0, 1, 1, 0, 0, 1, 0);
    add(0, 77, 1, 0, 1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    add(1, 1, 1, 0, 1, 1, 1, 10, 2, 0);
    add(0, 0, 0, 0, 1, 0, 0, 10, 2, 0);
    add(0, 0, 0, 0, 1, 1, 0, 10, 2, 0);

    do_reset();
    check("reset in_ready", in_ready, 1);
    check_out("reset", 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].c, vecs[i].o);
      check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ready);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_ovalid, vecs[i].e_sum,
                vecs[i].e_cnt, vecs[i].e_ovf);
    end

    // ---- saturation: 17 x 255 overflows a 12-bit accumulator on the last word ----
    for (int i = 0; i < 17; i++) begin
      drive(1, 255, (i == 16), 0, 1);
      tick();
    end
    check_out("sat17", 1, SUM_MAX, 17, 1);
    drive(0, 0, 0, 0, 1); tick();
    drive(1, 1, 1, 0, 1); tick();
    check_out("after_sat", 1, 1, 1, 0);
    drive(0, 0, 0, 0, 1); tick();

    // ---- sample counter saturation: 300 words of 1 ----
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, (i == 299), 0, 1);
      tick();
    end
    check_out("cnt_sat", 1, 300, CNT_MAX, 0);
    drive(0, 0, 0, 0, 1); tick();

    // ---- reset while a result is held ----
    drive(1, 2, 0, 0, 0); tick();
    drive(1, 3, 1, 0, 0); tick();
    check_out("pre_rst_hold", 1, 5, 2, 0);
    do_reset();
    drive(0, 0, 0, 0, 0);
    check("rst_hold in_ready", in_ready, 1);
    check_out("rst_hold", 0, 0, 0, 0);

    // ---- reset mid-packet discards the partial sum ----
    drive(1, 100, 0, 0, 1); tick();
    do_reset();
    drive(1, 1, 1, 0, 1); tick();
    check_out("rst_mid", 1, 1, 1, 0);
    drive(0, 0, 0, 0, 1); tick();

    // ---- randomized run against the packet model ----
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic v, l, c, o, exp_ready;
      int   d;
      v = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      l = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 39) == 0);
      o = ($urandom_range(0, 9) < 6);
      drive(v, d, l, c, o);
      exp_ready = !m_busy && !c;
      check($sformatf("rnd%0d in_ready", cyc), in_ready, exp_ready);
      tick();
      if (m_busy) begin
        if (o) m_busy = 1'b0;
      end else if (c) begin
        pkt.delete();
      end else if (v) begin
        pkt.push_back(d);
        if (l) model_finish_packet();
      end
      check_out($sformatf("rnd%0d", cyc), m_busy, m_sum, m_cnt, m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/coe_accum.md
Name: coe_accum

Overview:
- Sequential accumulator directly downstream of the WIDTH-bit ripple adder datapath.
- Consumes a stream of unsigned WIDTH-bit coefficient words on a valid/ready handshake.
- Sums each packet, delimited by in_last, into a wider guarded accumulator.
- Emits one result word per packet with sample count and sticky overflow flag, with backpressure.

Parameters:
- WIDTH, `W_COE (8): input word width.
- GUARD, 4: guard bits. Accumulator width ACC_W = WIDTH+GUARD, a derived localparam.
- CNT_W, 8: sample-counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous clear of the in-progress packet.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  WIDTH  unsigned coefficient word.
- in_last  in  1  marks final word of packet.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  packet sum, saturated.
- out_cnt  out  CNT_W  number of words in packet, saturated.
- out_ovf  out  1  sum saturated during packet.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. rst has priority over everything.
- Reset state: state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
- Two states: ACC (accepting words) and HOLD (result presented).
- in_ready = (state==ACC) && !clr. It is combinational and never depends on in_valid.
- Beat: in_valid && in_ready in the same cycle.
- Per beat:
  - acc_next = acc + zero-extended in_data, computed at ACC_W+1 bits.
  - If bit ACC_W of the sum is set, acc_next = all-ones and ovf is set (sticky).
  - Once saturated, acc stays all-ones for the remainder of the packet.
  - cnt_next = cnt+1, saturating at 2^CNT_W-1.
- Beat with in_last=0: acc<=acc_next, cnt<=cnt_next, ovf updated; state stays ACC.
- Beat with in_last=1:
  - out_sum<=acc_next, out_cnt<=cnt_next, out_ovf<=ovf_next, out_valid<=1.
  - Internal acc, cnt and ovf are cleared; state<=HOLD.
  - Latency: result is visible on the cycle after the last beat.
- HOLD:
  - in_ready=0.
  - out_* hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid<=0, state<=ACC. The next word can be accepted on the following cycle; no same-cycle bypass.
  - out_sum, out_cnt and out_ovf keep their last values after the handshake.
- Throughput: each packet costs its word count plus at least 1 HOLD cycle.
- clr in ACC: acc, cnt and ovf clear to 0. No beat occurs that cycle because in_ready is low.
- clr in HOLD: no effect on the held result or on the state.
- rst mid-packet or in HOLD: partial sum discarded; out_valid=0 and in_ready=1 on the next cycle.
- Idle gaps (in_valid=0) inside a packet leave acc and cnt unchanged.
- A packet of one word (in_last on the first beat) is legal.

Test Plan:
1. rst, then beats 10, 20, 30 (last), out_ready=1 → out_valid=1 the cycle after the 30 beat; out_sum=60, out_cnt=3, out_ovf=0. in_ready=1 again one cycle after the result handshake.
2. 17 beats of 255 with defaults (ACC_W=12) → after 16 beats acc=4080; the 17th beat saturates; out_sum=4095, out_ovf=1, out_cnt=17. The next packet of 1 (last) gives out_sum=1, out_ovf=0.
3. Packet 3, 4 (last) with out_ready=0 for 5 cycles → out_valid=1 with out_sum=7 held stable, in_ready=0 throughout. Raise out_ready → out_valid=0 next cycle, in_ready=1.
4. Beats 5, 5, then clr with in_valid=1 (word dropped, in_ready=0), then 7 (last) → out_sum=7, out_cnt=1. Also: single beat 0 (last) → out_sum=0, out_cnt=1.
5. Beats 9, idle 3 cycles, 1 (last), with in_valid toggling → out_sum=10, out_cnt=2. Also: rst asserted while in HOLD → out_valid=0, in_ready=1, out_sum=0 next cycle.
